// File: rtl/kgp_pkg.sv
// Shared encodings for the KGP-RISC multi-cycle control path: FSM states,
// the halt opcode and the PC source select values.
package kgp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_ERROR  = 3'd7
    } state_t;

    localparam logic [5:0] HALT_OPCODE = 6'b111111;

    localparam logic PC_INC = 1'b0;
    localparam logic PC_TGT = 1'b1;

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Bundle between the sequencer, the decode unit and the datapath/memory.
// The slave side is the sequencer; the master side is everything around it.
interface multicycle_sequencer_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             is_branch;
    logic             branch_taken;
    logic             mem_ready;
    logic             mem_req;
    logic             mem_we;
    logic             mem_addr_sel;
    logic             ir_load;
    logic             rf_we;
    logic             pc_write;
    logic             pc_src;
    logic             halted;
    logic             err;
    logic [2:0]       state;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] instret_cnt;

    modport master (
        output opcode, reg_write, mem_read, mem_write, is_branch, branch_taken, mem_ready,
        input  mem_req, mem_we, mem_addr_sel, ir_load, rf_we, pc_write, pc_src,
        input  halted, err, state, cycle_cnt, instret_cnt
    );

    modport slave (
        input  opcode, reg_write, mem_read, mem_write, is_branch, branch_taken, mem_ready,
        output mem_req, mem_we, mem_addr_sel, ir_load, rf_we, pc_write, pc_src,
        output halted, err, state, cycle_cnt, instret_cnt
    );
endinterface

// File: rtl/multicycle_sequencer_mem_watchdog.sv
// Counts stalled memory cycles and flags a timeout once TIMEOUT stalls have
// elapsed without a ready; a ready in that same cycle still wins.
module mem_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic ready,
    output logic timeout
);
    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (!rst || !active || ready) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + W'(1);
        end
    end

    assign timeout = active && !ready && (wait_cnt == W'(TIMEOUT));

endmodule

// File: rtl/multicycle_sequencer.sv
// Phase controller stepping each instruction through FETCH/DECODE/EXEC/MEM/WB,
// gating decode controls to their phase and counting cycles and retirements.
module multicycle_sequencer
    import kgp_pkg::*;
#(
    parameter logic [5:0] HALT_OP = HALT_OPCODE,
    parameter int         TIMEOUT = 255,
    parameter int         CNT_W   = 32
) (
    input logic                  clk,
    input logic                  rst,
    multicycle_sequencer_if.slave bus
);
    state_t           state_q;
    state_t           state_d;
    logic             taken_q;
    logic [CNT_W-1:0] cycle_q;
    logic [CNT_W-1:0] instret_q;
    logic             timeout;
    logic             mem_req, mem_we, mem_addr_sel, ir_load, rf_we, pc_write, pc_src;

    mem_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .active ((state_q == ST_FETCH) || (state_q == ST_MEM)),
        .ready  (bus.mem_ready),
        .timeout(timeout)
    );

    always_comb begin
        state_d      = state_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_load      = 1'b0;
        rf_we        = 1'b0;
        pc_write     = 1'b0;
        pc_src       = PC_INC;
        unique case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                mem_req = 1'b1;
                if (bus.mem_ready) begin
                    ir_load = 1'b1;
                    state_d = ST_DECODE;
                end else if (timeout) begin
                    state_d = ST_ERROR;
                end
            end
            ST_DECODE: state_d = (bus.opcode == HALT_OP) ? ST_HALT : ST_EXEC;
            ST_EXEC: begin
                if (bus.is_branch && bus.reg_write) begin
                    state_d = ST_WB;
                end else if (bus.is_branch) begin
                    pc_write = 1'b1;
                    pc_src   = bus.branch_taken ? PC_TGT : PC_INC;
                    state_d  = ST_FETCH;
                end else if (bus.mem_read || bus.mem_write) begin
                    state_d = ST_MEM;
                end else if (bus.reg_write) begin
                    state_d = ST_WB;
                end else begin
                    pc_write = 1'b1;
                    state_d  = ST_FETCH;
                end
            end
            ST_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = bus.mem_write;
                if (bus.mem_ready) begin
                    if (bus.mem_read) begin
                        state_d = ST_WB;
                    end else begin
                        pc_write = 1'b1;
                        state_d  = ST_FETCH;
                    end
                end else if (timeout) begin
                    state_d = ST_ERROR;
                end
            end
            ST_WB: begin
                rf_we    = 1'b1;
                pc_write = 1'b1;
                pc_src   = taken_q ? PC_TGT : PC_INC;
                state_d  = ST_FETCH;
            end
            default: state_d = state_q;
        endcase
        // A reset edge aborts the instruction, so no architectural write may fire alongside it.
        if (!rst) begin
            ir_load  = 1'b0;
            rf_we    = 1'b0;
            pc_write = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            taken_q   <= 1'b0;
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            cycle_q <= cycle_q + CNT_W'(1);
            if (pc_write) begin
                instret_q <= instret_q + CNT_W'(1);
            end
            if (state_q == ST_EXEC) begin
                taken_q <= bus.branch_taken && bus.is_branch;
            end
        end
    end

    assign bus.mem_req      = mem_req;
    assign bus.mem_we       = mem_we;
    assign bus.mem_addr_sel = mem_addr_sel;
    assign bus.ir_load      = ir_load;
    assign bus.rf_we        = rf_we;
    assign bus.pc_write     = pc_write;
    assign bus.pc_src       = pc_src;
    assign bus.halted       = (state_q == ST_HALT);
    assign bus.err          = (state_q == ST_ERROR);
    assign bus.state        = state_q;
    assign bus.cycle_cnt    = cycle_q;
    assign bus.instret_cnt  = instret_q;

endmodule
